ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the opposite direction of `PS2_receiver` and shares the same PS2 clock and data lines. It drives both lines open-drain through output-enable signals: asserting an enable pulls the line low, and the top-level tristate handles the pin. The block runs the full request-to-send sequence, serial framing, odd parity and device-acknowledge check, then reports done or error to the game logic.

---
 rtl/ps2_transmitter.sv | 193 +++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command sender.
// Runs the request-to-send sequence (hold clock low, pull data low), then
// shifts out D0..D7, odd parity and stop on device clock falling edges, checks
// the device acknowledge and reports done or error. Lines are open-drain: an
// asserted *_oe pulls the corresponding line low.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   PS2clk, key_data    PS/2 clock/data as seen at the pins (asynchronous)
//   ps2_clk_oe          1 = pull PS/2 clock low
//   ps2_data_oe         1 = pull PS/2 data low
//   tx_data, tx_start   command byte and single-cycle send request
//   tx_busy             transaction in progress
//   tx_done, tx_err     one-cycle completion / NACK-or-timeout pulses
//
// Build option: define PS2_TX_TIMEOUT_EN to abort (tx_err) when the device
// stops clocking for TIMEOUT_CYCLES cycles.
module ps2_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2clk,
  input  logic       key_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [IW-1:0] inh_q, inh_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
  logic          fe, tx_bit, to_hit;

  assign fe = clk_prev_q & ~clk_sync_q;

  // Synchronizers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= key_data;
      dat_sync_q <= dat_meta_q;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_q, to_d;

  // Counts cycles since the last device edge; held at zero outside the
  // device-clocked states, so entering SEND starts from zero.
  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if ((state_q == SEND || state_q == ACK || state_q == RELEASE) && !(done_q | err_q)) begin
      if (fe)                                     to_d   = '0;
      else if (to_q == TW'(TIMEOUT_CYCLES - 1))   to_hit = 1'b1;
      else                                        to_d   = to_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      par_q     <= 1'b0;
      bitcnt_q  <= '0;
      inh_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      bitcnt_q  <= bitcnt_d;
      inh_q     <= inh_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state. A done/err pulse is issued while still in the ending state;
  // the FSM drops to IDLE on the following cycle so busy falls after the pulse.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    inh_d    = inh_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q != IDLE && (done_q || err_q)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (tx_start) begin
          sh_d     = tx_data;
          par_d    = ~^tx_data;
          bitcnt_d = '0;
          inh_d    = '0;
          state_d  = INHIBIT;
        end
        INHIBIT: begin
          if (inh_q == IW'(INHIBIT_CYCLES - 1)) state_d = REQ;
          else                                  inh_d   = inh_q + IW'(1);
        end
        REQ: state_d = SEND;
        SEND: if (fe) begin
          bitcnt_d = bitcnt_q + 4'd1;
          // sh[0] already holds D0 for edge 1; shift for edges 2..8
          if (bitcnt_q >= 4'd1 && bitcnt_q < 4'd8) sh_d = {1'b0, sh_q[7:1]};
          if (bitcnt_q == 4'd9) state_d = ACK;   // edge 10: stop bit = released line
        end
        ACK: if (fe) begin
          if (!dat_sync_q) state_d = RELEASE;
          else             err_d   = 1'b1;
        end
        RELEASE: if (clk_sync_q && dat_sync_q) done_d = 1'b1;
        default: state_d = IDLE;
      endcase
      if (to_hit && !done_d) err_d = 1'b1;
    end
  end

  // Bit on the wire in SEND: start, D0..D7, then parity.
  always_comb begin
    tx_bit = par_d;
    if (bitcnt_d == 4'd0)       tx_bit = 1'b0;
    else if (bitcnt_d <= 4'd8)  tx_bit = sh_d[0];
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = (state_d != IDLE);
    if (!(done_d || err_d)) begin
      case (state_d)
        INHIBIT: clk_oe_d = 1'b1;
        REQ: begin
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b1;
        end
        SEND:    data_oe_d = ~tx_bit;
        default: ;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
module tb_ps2_transmitter;
  localparam int INH  = 300;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic clk = 1'b0, reset = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
  wire  clk_line  = ~(ps2_clk_oe | dev_clk_low);
  wire  data_line = ~(ps2_data_oe | dev_data_low);

  int nchk = 0, nerr = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int done_cyc = 0, err_cyc = 0, busy_fall_cyc = 0, run = 0, last_run = 0;
  int edge_fall_cyc = 0;
  logic busy_prev = 1'b0;

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .PS2clk(clk_line), .key_data(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_done) begin done_cnt++; done_cyc = cyc; end
    if (tx_err) begin err_cnt++; err_cyc = cyc; end
    if (tx_done && tx_err) both_cnt++;
    if (ps2_clk_oe) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    if (busy_prev && !tx_busy) busy_fall_cyc = cyc;
    busy_prev = tx_busy;
  end

  // Expected frame as the device sees it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b, output bit lat_ok);
    logic pre;
    @(negedge clk);
    pre = ps2_clk_oe;
    tx_data = b; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; tx_data = 8'($urandom);
    lat_ok = (pre == 1'b0) && (ps2_clk_oe == 1'b1) && (tx_busy == 1'b1);
  endtask

  // Device: clocks the frame, sampling data while clock is high before each
  // falling edge. stop_after>0 leaves clock held low after that edge.
  task automatic dev_frame(input bit ack, input int stop_after,
                           output logic [10:0] bits, output bit ok);
    int n = 0;
    bits = '0; ok = 1'b1;
    while (!(ps2_clk_oe == 1'b0 && data_line == 1'b0) && n < INH + 100) begin
      @(negedge clk); n++;
    end
    if (n >= INH + 100) begin ok = 1'b0; return; end
    for (int k = 1; k <= 11; k++) begin
      wait_cyc(HALF);
      bits[k-1] = data_line;
      if (k == 11 && ack) begin dev_data_low = 1'b1; wait_cyc(2); end
      dev_clk_low = 1'b1;
      edge_fall_cyc = cyc;
      if (k == stop_after) return;
      wait_cyc(HALF);
      dev_clk_low = 1'b0;
    end
    wait_cyc(HALF);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (tx_busy && n < limit) begin @(negedge clk); n++; end
    ok = !tx_busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cyc(4);
    nchk++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err} !== 5'b0) begin
      nerr++; $display("FAIL reset_outputs: got %b want 00000",
                       {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err});
    end
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_send(input logic [7:0] b);
    bit lat, ok, idle;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(b, lat);
    dev_frame(1'b1, 0, bits, ok);
    wait_idle(500, idle);
    wait_cyc(2);
    nchk++; if (!lat) begin nerr++; $display("FAIL send_%h_latency: clk_oe not high 1 cycle after start", b); end
    nchk++; if (!ok || !idle) begin nerr++; $display("FAIL send_%h_timing: start_seen=%0d idle=%0d want 1 1", b, ok, idle); end
    nchk++; if (bits !== frame_of(b)) begin nerr++; $display("FAIL send_%h_frame: got %b want %b", b, bits, frame_of(b)); end
    nchk++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      nerr++; $display("FAIL send_%h_pulses: done=%0d err=%0d want 1 0", b, done_cnt - d0, err_cnt - e0); end
    nchk++; if (last_run != INH + 1) begin nerr++; $display("FAIL send_%h_inhibit: got %0d want %0d", b, last_run, INH + 1); end
    nchk++; if (busy_fall_cyc != done_cyc + 1) begin
      nerr++; $display("FAIL send_%h_busy_fall: got %0d want %0d", b, busy_fall_cyc, done_cyc + 1); end
    nchk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      nerr++; $display("FAIL send_%h_release: oe=%b want 00", b, {ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_nack;
    bit lat, ok, idle;
    logic [10:0] bits;
    logic [7:0] b = 8'($urandom);
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(b, lat);
    dev_frame(1'b0, 0, bits, ok);
    wait_idle(500, idle);
    wait_cyc(2);
    nchk++; if (bits !== frame_of(b) || !ok || !idle) begin
      nerr++; $display("FAIL nack_frame: got %b want %b ok=%0d idle=%0d", bits, frame_of(b), ok, idle); end
    nchk++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      nerr++; $display("FAIL nack_pulses: err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
    nchk++; if (busy_fall_cyc != err_cyc + 1 || {clk_line, data_line} !== 2'b11) begin
      nerr++; $display("FAIL nack_release: busy_fall=%0d want %0d lines=%b", busy_fall_cyc, err_cyc + 1, {clk_line, data_line}); end
  endtask

  task automatic test_timeout;
    bit lat, ok;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(8'h3C, lat);
    dev_frame(1'b1, 4, bits, ok);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      while (err_cnt == e0 && n < TO + 200) begin @(negedge clk); n++; end
      nchk++; if (err_cnt - e0 != 1 || (err_cyc - edge_fall_cyc) < TO || (err_cyc - edge_fall_cyc) > TO + 10) begin
        nerr++; $display("FAIL timeout_err: errs=%0d delay=%0d want 1 and %0d..%0d", err_cnt - e0, err_cyc - edge_fall_cyc, TO, TO + 10); end
      nchk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || done_cnt != d0) begin
        nerr++; $display("FAIL timeout_release: oe=%b done=%0d want 00 0", {ps2_clk_oe, ps2_data_oe}, done_cnt - d0); end
      wait_cyc(3);
      nchk++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL timeout_busy: got %b want 0", tx_busy); end
      dev_clk_low = 1'b0;
      wait_cyc(10);
    end
`else
    wait_cyc(TO + 200);
    nchk++; if (tx_busy !== 1'b1 || err_cnt != e0 || done_cnt != d0) begin
      nerr++; $display("FAIL no_timeout_wait: busy=%b err=%0d done=%0d want 1 0 0", tx_busy, err_cnt - e0, done_cnt - d0); end
    reset = 1'b1; dev_clk_low = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
`endif
    nchk++; if (!ok) begin nerr++; $display("FAIL timeout_start: device never saw request"); end
  endtask

  task automatic test_reset_mid;
    bit lat, ok;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(8'hA7, lat);
    dev_frame(1'b1, 5, bits, ok);
    wait_cyc(4);
    #1 reset = 1'b1;
    #1;
    nchk++; if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      nerr++; $display("FAIL reset_mid_async: oe/busy=%b want 000", {ps2_clk_oe, ps2_data_oe, tx_busy}); end
    wait_cyc(3);
    dev_clk_low = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(50);
    nchk++; if (done_cnt != d0 || err_cnt != e0 || !ok) begin
      nerr++; $display("FAIL reset_mid_pulses: done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_send(8'hFF);
  endtask

  task automatic test_ignore_start;
    bit lat, ok, idle;
    logic [10:0] bits;
    int d0 = done_cnt;
    start_tx(8'hED, lat);
    fork
      dev_frame(1'b1, 0, bits, ok);
      begin
        wait_cyc(100);
        tx_data = 8'h12; tx_start = 1'b1; wait_cyc(1); tx_start = 1'b0;
        wait_cyc(INH);
        tx_data = 8'h12; tx_start = 1'b1; wait_cyc(1); tx_start = 1'b0;
      end
    join
    wait_idle(500, idle);
    wait_cyc(20);
    nchk++; if (bits !== frame_of(8'hED) || !ok || !idle) begin
      nerr++; $display("FAIL ignore_frame: got %b want %b", bits, frame_of(8'hED)); end
    nchk++; if (done_cnt - d0 != 1 || tx_busy !== 1'b0) begin
      nerr++; $display("FAIL ignore_done: done=%0d busy=%b want 1 0", done_cnt - d0, tx_busy); end
  endtask

  task automatic test_exclusive;
    nchk++; if (both_cnt != 0) begin nerr++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_send(8'hED);
    test_send(8'hF4);
    test_send(8'h00);
    for (int i = 0; i < 4; i++) test_send(8'($urandom));
    test_nack;
    test_timeout;
    test_reset_mid;
    test_ignore_start;
    test_exclusive;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
